// File: rtl/nibarb_pkg.sv
// ---------------------------------------------------------------------------
// nibarb_pkg
// Shared definitions for the nibble state arbiter:
//   - FSM state encoding (IDLE / WRITE / CLEAR) and its enum type
//   - requester identifiers (A / B)
//   - default STATE width and clear value
// No ports; imported by rr_arbiter2 and nibble_state_arbiter.
// ---------------------------------------------------------------------------
package nibarb_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] CLEAR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_WRITE = WRITE,
      ST_CLEAR = CLEAR
   } state_t;

   localparam logic REQ_ID_A = 1'b0;
   localparam logic REQ_ID_B = 1'b1;

   localparam int         NIBARB_DW      = 8;
   localparam logic [7:0] NIBARB_CLR_VAL = 8'h00;

endpackage : nibarb_pkg

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin pick. The priority pointer is
// owned by the caller; this block only decides who would win right now.
//
// Ports:
//   i_req     [1:0]  request vector, index REQ_ID_A / REQ_ID_B
//   i_ptr            requester holding priority when both request
//   o_win_id         selected requester (meaningful only when o_any_req)
//   o_any_req        at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter2
   import nibarb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic       o_win_id,
   output logic       o_any_req
);

   logic w_both;

   assign w_both    = i_req[REQ_ID_A] & i_req[REQ_ID_B];
   assign o_any_req = |i_req;

   // A sole requester always wins; the pointer only breaks ties.
   always_comb begin
      o_win_id = REQ_ID_A;
      if (w_both) begin
         o_win_id = i_ptr;
      end else if (i_req[REQ_ID_B]) begin
         o_win_id = REQ_ID_B;
      end
   end

endmodule : rr_arbiter2

// File: rtl/nibble_state_arbiter.sv
// ---------------------------------------------------------------------------
// nibble_state_arbiter
// Two requesters share one DW-bit STATE register. Each granted write
// replaces one half (nibble) of STATE; CLR synchronously loads CLR_VAL and
// overrides any pending write. Round-robin between A and B, at most one
// committed write every two clocks (IDLE arbitrates, WRITE commits).
//
// Ports:
//   CLOCK            rising-edge clock
//   RST              asynchronous active-high reset
//   CLR              synchronous clear, highest priority
//   REQ_A/REQ_B      write requests, held until the grant is sampled
//   NIB_A/NIB_B      target half: 0 = STATE[0:HW-1], 1 = STATE[HW:DW-1]
//   DATA_A/DATA_B    write data (HW bits), stable while REQ is high
//   GNT_A/GNT_B      grant; STATE is written at the edge ending this cycle
//   STATE            shared register, bit 0 is the MSB
//   BUSY             FSM is not in IDLE
//   STATE_PAR        (only with NIBARB_PARITY_EN) registered XOR of STATE
//
// Optional feature macro: NIBARB_PARITY_EN
// ---------------------------------------------------------------------------
module nibble_state_arbiter
   import nibarb_pkg::*;
#(
   parameter int              DW      = NIBARB_DW,
   parameter logic [DW-1:0]   CLR_VAL = DW'(NIBARB_CLR_VAL)
)
(
   input  logic               CLOCK,
   input  logic               RST,
   input  logic               CLR,
   input  logic               REQ_A,
   input  logic               NIB_A,
   input  logic [DW/2-1:0]    DATA_A,
   output logic               GNT_A,
   input  logic               REQ_B,
   input  logic               NIB_B,
   input  logic [DW/2-1:0]    DATA_B,
   output logic               GNT_B,
   output logic [0:DW-1]      STATE,
`ifdef NIBARB_PARITY_EN
   output logic               STATE_PAR,
`endif
   output logic               BUSY
);

   localparam int HW = DW / 2;

   state_t            r_fsm;
   state_t            w_fsm_nxt;
   logic              r_winner;
   logic              r_ptr;
   logic [0:DW-1]     r_state;
   logic [0:DW-1]     w_state_nxt;

   logic              w_win_id;
   logic              w_any_req;
   logic              w_wr_en;
   logic              w_wr_nib;
   logic [HW-1:0]     w_wr_data;

   rr_arbiter2 u_rr_arbiter2 (
      .i_req     ({REQ_B, REQ_A}),
      .i_ptr     (r_ptr),
      .o_win_id  (w_win_id),
      .o_any_req (w_any_req)
   );

   // A write commits only from WRITE and only if CLR does not override it;
   // the grant is exactly this commit condition, decoded per requester.
   assign w_wr_en   = (r_fsm == ST_WRITE) && !CLR;
   assign GNT_A     = w_wr_en && (r_winner == REQ_ID_A);
   assign GNT_B     = w_wr_en && (r_winner == REQ_ID_B);
   assign w_wr_nib  = (r_winner == REQ_ID_B) ? NIB_B  : NIB_A;
   assign w_wr_data = (r_winner == REQ_ID_B) ? DATA_B : DATA_A;

   assign BUSY  = (r_fsm != ST_IDLE);
   assign STATE = r_state;

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         ST_IDLE: begin
            if (CLR) begin
               w_fsm_nxt = ST_CLEAR;
            end else if (w_any_req) begin
               w_fsm_nxt = ST_WRITE;
            end
         end
         ST_WRITE: w_fsm_nxt = CLR ? ST_CLEAR : ST_IDLE;
         ST_CLEAR: w_fsm_nxt = CLR ? ST_CLEAR : ST_IDLE;
         default:  w_fsm_nxt = ST_IDLE;
      endcase
   end

   // Clear is a priority load rather than a forced value, so STATE keeps a
   // single synchronous driver.
   always_comb begin
      w_state_nxt = r_state;
      if (CLR) begin
         w_state_nxt = CLR_VAL;
      end else if (w_wr_en) begin
         if (w_wr_nib == 1'b0) begin
            w_state_nxt[0:HW-1]  = w_wr_data;
         end else begin
            w_state_nxt[HW:DW-1] = w_wr_data;
         end
      end
   end

   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         r_fsm    <= ST_IDLE;
         r_winner <= REQ_ID_A;
         r_ptr    <= REQ_ID_A;
         r_state  <= CLR_VAL;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_state <= w_state_nxt;
         // Winner is frozen for the whole WRITE cycle so the grant cannot
         // hop between requesters if inputs change.
         if ((r_fsm == ST_IDLE) && !CLR && w_any_req) begin
            r_winner <= w_win_id;
         end
         // An aborted (cleared) write leaves the pointer alone so the same
         // requester keeps its turn.
         if (w_wr_en) begin
            r_ptr <= ~r_winner;
         end
      end
   end

`ifdef NIBARB_PARITY_EN
   logic r_par;

   always_ff @(posedge CLOCK or posedge RST) begin
      if (RST) begin
         r_par <= ^CLR_VAL;
      end else begin
         r_par <= ^w_state_nxt;
      end
   end

   assign STATE_PAR = r_par;
`endif

endmodule : nibble_state_arbiter

// File: tb/tb_nibble_state_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nibble_state_arbiter
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a transaction-level model of the shared register.
// ---------------------------------------------------------------------------
module tb_nibble_state_arbiter;

   localparam int DW = 8;
   localparam int HW = DW / 2;
   localparam int CLR_V = 0;

   logic          CLOCK = 1'b0;
   logic          RST   = 1'b1;
   logic          CLR   = 1'b0;
   logic          REQ_A = 1'b0;
   logic          NIB_A = 1'b0;
   logic [HW-1:0] DATA_A = '0;
   logic          GNT_A;
   logic          REQ_B = 1'b0;
   logic          NIB_B = 1'b0;
   logic [HW-1:0] DATA_B = '0;
   logic          GNT_B;
   logic [0:DW-1] STATE;
   logic          BUSY;
`ifdef NIBARB_PARITY_EN
   logic          STATE_PAR;
`endif

   int n_err = 0;
   int n_chk = 0;

   // Model: register value, whose turn it is on a tie, and what the block
   // is currently doing (-1 nothing, 0 serving A, 1 serving B, 2 clearing).
   int m_state;
   int m_ptr;
   int m_who;
   bit done_a, done_b;
   int glog[$];

   nibble_state_arbiter dut (
      .CLOCK  (CLOCK),
      .RST    (RST),
      .CLR    (CLR),
      .REQ_A  (REQ_A),
      .NIB_A  (NIB_A),
      .DATA_A (DATA_A),
      .GNT_A  (GNT_A),
      .REQ_B  (REQ_B),
      .NIB_B  (NIB_B),
      .DATA_B (DATA_B),
      .GNT_B  (GNT_B),
      .STATE  (STATE),
`ifdef NIBARB_PARITY_EN
      .STATE_PAR (STATE_PAR),
`endif
      .BUSY   (BUSY)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int put_nib(input int cur, input bit nib, input int data);
      // Half 0 holds the numerically upper bits because bit 0 is the MSB.
      if (nib == 1'b0) return (cur & ((1 << HW) - 1)) | (data << HW);
      else             return (cur & (((1 << HW) - 1) << HW)) | data;
   endfunction

   task automatic model_reset();
      m_state = CLR_V;
      m_ptr   = 0;
      m_who   = -1;
      done_a  = 1'b0;
      done_b  = 1'b0;
   endtask

   task automatic model_edge();
      done_a = 1'b0;
      done_b = 1'b0;
      if (CLR) begin
         m_state = CLR_V;
         m_who   = 2;
      end else begin
         case (m_who)
            -1: begin
               if (REQ_A && REQ_B) m_who = m_ptr;
               else if (REQ_A)     m_who = 0;
               else if (REQ_B)     m_who = 1;
            end
            0: begin
               chk("proto_req_a_held", REQ_A, 1'b1);
               m_state = put_nib(m_state, NIB_A, int'(DATA_A));
               m_ptr = 1; m_who = -1; done_a = 1'b1;
            end
            1: begin
               chk("proto_req_b_held", REQ_B, 1'b1);
               m_state = put_nib(m_state, NIB_B, int'(DATA_B));
               m_ptr = 0; m_who = -1; done_b = 1'b1;
            end
            default: m_who = -1;
         endcase
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance model at the edge.
   task automatic cycle();
      @(negedge CLOCK);
      chk("gnt_a", GNT_A, (m_who == 0) && !CLR);
      chk("gnt_b", GNT_B, (m_who == 1) && !CLR);
      chk("busy",  BUSY,  m_who != -1);
      chk("state", STATE, m_state);
`ifdef NIBARB_PARITY_EN
      chk("parity", STATE_PAR, ^m_state[DW-1:0]);
`endif
      if (GNT_A) glog.push_back(0);
      if (GNT_B) glog.push_back(1);
      @(posedge CLOCK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; CLR = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
      @(posedge CLOCK);
      #1;
      RST = 1'b0;
      model_reset();
   endtask

   task automatic do_write(input bit who, input bit nib, input logic [HW-1:0] data);
      if (who == 1'b0) begin REQ_A = 1'b1; NIB_A = nib; DATA_A = data; end
      else             begin REQ_B = 1'b1; NIB_B = nib; DATA_B = data; end
      cycle();
      cycle();
      REQ_A = 1'b0;
      REQ_B = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      do_reset();

      // reset then idle
      chk("rst_state", STATE, 8'h00);
      chk("rst_busy", BUSY, 1'b0);
      repeat (10) cycle();

      // single writes, one per half
      do_write(1'b0, 1'b0, 4'hA);
      chk("wr_a_state", STATE, 8'hA0);
      do_write(1'b1, 1'b1, 4'h5);
      chk("wr_b_state", STATE, 8'hA5);

      // contention from reset: A, B, A, B
      do_reset();
      glog.delete();
      REQ_A = 1'b1; NIB_A = 1'b0; DATA_A = 4'h3;
      REQ_B = 1'b1; NIB_B = 1'b1; DATA_B = 4'hC;
      repeat (8) cycle();
      REQ_A = 1'b0; REQ_B = 1'b0;
      chk("cont_count", glog.size(), 4);
      for (int i = 0; i < glog.size() && i < 4; i++)
         chk("cont_order", glog[i], i % 2);
      chk("cont_state", STATE, 8'h3C);

      // clear aborts a granted write; requester is re-granted later
      do_reset();
      do_write(1'b0, 1'b0, 4'hA);
      do_write(1'b1, 1'b1, 4'h5);
      REQ_A = 1'b1; NIB_A = 1'b0; DATA_A = 4'hF;
      cycle();
      CLR = 1'b1;
      @(negedge CLOCK);
      chk("clr_gnt_a", GNT_A, 1'b0);
      @(posedge CLOCK); model_edge(); #1;
      chk("clr_state", STATE, 8'h00);
      CLR = 1'b0;
      cycle();
      cycle();
      cycle();
      REQ_A = 1'b0;
      chk("clr_regrant", STATE, 8'hF0);

      // asynchronous reset in the middle of a WRITE cycle
      REQ_A = 1'b1; NIB_A = 1'b1; DATA_A = 4'h3;
      cycle();
      chk("arst_pre_gnt", GNT_A, 1'b1);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_state", STATE, 8'h00);
      chk("arst_gnt", GNT_A, 1'b0);
      chk("arst_busy", BUSY, 1'b0);
      REQ_A = 1'b0;
      @(posedge CLOCK);
      #1;
      RST = 1'b0;
      model_reset();

`ifdef NIBARB_PARITY_EN
      do_write(1'b0, 1'b0, 4'hA);
      do_write(1'b1, 1'b1, 4'h5);
      chk("par_a5", STATE_PAR, 1'b0);
      do_write(1'b0, 1'b0, 4'hB);
      chk("par_b5_state", STATE, 8'hB5);
      chk("par_b5", STATE_PAR, 1'b1);
`endif

      // randomized traffic obeying the handshake
      for (int n = 0; n < 400; n++) begin
         if (REQ_A && done_a) begin
            if ($urandom_range(1, 0) == 0) REQ_A = 1'b0;
            else begin NIB_A = 1'($urandom); DATA_A = HW'($urandom); end
         end else if (!REQ_A && $urandom_range(2, 0) == 0) begin
            REQ_A = 1'b1; NIB_A = 1'($urandom); DATA_A = HW'($urandom);
         end
         if (REQ_B && done_b) begin
            if ($urandom_range(1, 0) == 0) REQ_B = 1'b0;
            else begin NIB_B = 1'($urandom); DATA_B = HW'($urandom); end
         end else if (!REQ_B && $urandom_range(2, 0) == 0) begin
            REQ_B = 1'b1; NIB_B = 1'($urandom); DATA_B = HW'($urandom);
         end
         CLR = ($urandom_range(11, 0) == 0);
         cycle();
      end
      CLR = 1'b0;
      REQ_A = 1'b0;
      REQ_B = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_nibble_state_arbiter
